// File: rtl/dmem_responder.sv
// Data-memory responder for the memory stage: word-organised synchronous RAM with big-endian
// byte lanes, a configurable number of wait states, and a stall held until the access completes.
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] addr,
  input  logic [3:0]  wen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        addr_err,
  output logic [1:0]  dbgState
);

  // Handshake: the core raises en with addr/wen/wdata and holds them stable while stall=1.
  // The access is complete in the single cycle where stall=0 after an accept (DONE); only then
  // are rdata and addr_err meaningful. An en seen in DONE belongs to the completing request.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } stateE;

  localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [3:0]  WAIT_CNT = 4'(WAIT_CYCLES);

  stateE       state;
  stateE       nextState;
  logic [3:0]  count;
  logic [31:0] addrQ;
  logic [3:0]  wenQ;
  logic [31:0] wdataQ;
  logic [31:0] rdReg;
  logic        errReg;
  logic [31:0] mem [DEPTH];

  logic                  accept;
  logic                  enterDone;
  logic [31:0]           accAddr;
  logic [3:0]            accWen;
  logic [31:0]           accWdata;
  logic [31:0]           offset;
  logic                  inRange;
  logic                  wenLegal;
  logic                  accessOk;
  logic [ADDR_WIDTH-1:0] wordIdx;

  // With no wait states the RAM is touched on the accept edge itself, so the live inputs
  // are used while IDLE and the latched copies otherwise.
  always_comb begin
    accAddr  = addrQ;
    accWen   = wenQ;
    accWdata = wdataQ;
    if (state == IDLE) begin
      accAddr  = addr;
      accWen   = wen;
      accWdata = wdata;
    end
  end

  // Unsigned subtraction: an address below the base fails the compare, never wraps into range.
  assign offset  = accAddr - BASE_ADDR;
  assign inRange = (accAddr >= BASE_ADDR) && ((offset >> (ADDR_WIDTH + 2)) == 32'd0);
  assign wordIdx = offset[ADDR_WIDTH+1:2];

  always_comb begin
    wenLegal = 1'b0;
    case (accWen)
      4'b0000: wenLegal = 1'b1;
      4'b1111: wenLegal = (accAddr[1:0] == 2'b00);
      4'b1100: wenLegal = (accAddr[1:0] == 2'b00);
      4'b0011: wenLegal = (accAddr[1:0] == 2'b10);
      4'b1000: wenLegal = (accAddr[1:0] == 2'b00);
      4'b0100: wenLegal = (accAddr[1:0] == 2'b01);
      4'b0010: wenLegal = (accAddr[1:0] == 2'b10);
      4'b0001: wenLegal = (accAddr[1:0] == 2'b11);
      default: wenLegal = 1'b0;
    endcase
  end

  assign accessOk = inRange && wenLegal;

  always_comb begin
    nextState = state;
    stall     = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (en && !rst) begin
          stall     = 1'b1;
          accept    = 1'b1;
          nextState = (WAIT_CNT != 4'd0) ? BUSY : DONE;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (count == 4'd1) nextState = DONE;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  assign enterDone = (nextState == DONE) && (state != DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= 4'd0;
      addrQ  <= '0;
      wenQ   <= '0;
      wdataQ <= '0;
      rdReg  <= '0;
      errReg <= 1'b0;
    end else begin
      state <= nextState;
      if (accept) begin
        count  <= WAIT_CNT;
        addrQ  <= addr;
        wenQ   <= wen;
        wdataQ <= wdata;
      end else if (state == BUSY) begin
        count <= count - 4'd1;
      end
      if (enterDone) begin
        rdReg  <= accessOk ? mem[wordIdx] : 32'd0;
        errReg <= !accessOk;
      end
    end
  end

  // RAM is never reset; a reset on the completing edge drops the pending store.
  always_ff @(posedge clk) begin
    if (!rst && enterDone && accessOk) begin
      if (accWen[3]) mem[wordIdx][31:24] <= accWdata[31:24];
      if (accWen[2]) mem[wordIdx][23:16] <= accWdata[23:16];
      if (accWen[1]) mem[wordIdx][15:8]  <= accWdata[15:8];
      if (accWen[0]) mem[wordIdx][7:0]   <= accWdata[7:0];
    end
  end

  assign rdata    = (state == DONE) ? rdReg : 32'd0;
  assign addr_err = (state == DONE) && errReg;
  assign dbgState = state;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (one wait state at base 0, zero wait states at base
// 0x1000) driven from directed and random accesses against a per-cycle expected-output queue.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en_a    [2];
  logic [31:0] addr_a  [2];
  logic [3:0]  wen_a   [2];
  logic [31:0] wdata_a [2];
  logic [31:0] rdata_a [2];
  logic        stall_a [2];
  logic        err_a   [2];
  logic [1:0]  dbg_a   [2];

  dmem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(1)) u_dut0 (
    .clk(clk), .rst(rst), .en(en_a[0]), .addr(addr_a[0]), .wen(wen_a[0]), .wdata(wdata_a[0]),
    .rdata(rdata_a[0]), .stall(stall_a[0]), .addr_err(err_a[0]), .dbgState(dbg_a[0])
  );

  dmem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0000_1000), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .rst(rst), .en(en_a[1]), .addr(addr_a[1]), .wen(wen_a[1]), .wdata(wdata_a[1]),
    .rdata(rdata_a[1]), .stall(stall_a[1]), .addr_err(err_a[1]), .dbgState(dbg_a[1])
  );

  int n_cmp = 0;
  int n_bad = 0;
  int active = 0;

  // Per-cycle expectation: [36] check stall, [35] check addr_err, [34] check rdata,
  // [33] stall, [32] addr_err, [31:0] rdata.
  logic [36:0] exp_q[$];

  logic [31:0] mdl   [2][1024];
  bit          known [2][1024];

  function automatic logic [36:0] mk(bit cs, bit ce, bit cd, bit s, bit e, logic [31:0] r);
    return {cs, ce, cd, s, e, r};
  endfunction

  function automatic logic [31:0] base_of(int sel);
    return (sel == 0) ? 32'h0000_0000 : 32'h0000_1000;
  endfunction

  function automatic int wait_of(int sel);
    return (sel == 0) ? 1 : 0;
  endfunction

  // A store is legal when it covers 1, 2 or 4 contiguous bytes starting at a naturally
  // aligned byte offset; lane for byte offset b is wen[3-b].
  function automatic bit legal_wen(logic [31:0] a, logic [3:0] w);
    int n;
    int off;
    logic [3:0] ones;
    logic [3:0] m;
    n   = $countones(w);
    off = int'(a[1:0]);
    if (w == 4'b0000) return 1'b1;
    if (!(n == 1 || n == 2 || n == 4)) return 1'b0;
    if ((off % n) != 0) return 1'b0;
    ones = 4'((1 << n) - 1);
    m    = ones << (4 - n - off);
    return w == m;
  endfunction

  task automatic model_eval(input int sel, input logic [31:0] a, input logic [3:0] w,
                            output bit ok, output int idx);
    longint off;
    off = longint'(a) - longint'(base_of(sel));
    ok  = (off >= 0) && (off < 4 * 1024) && legal_wen(a, w);
    idx = ok ? int'(off / 4) : 0;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : cmp_blk
    logic [36:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (e[36]) check("stall", {31'b0, stall_a[active]}, {31'b0, e[33]});
      if (e[35]) check("addr_err", {31'b0, err_a[active]}, {31'b0, e[32]});
      if (e[34]) check("rdata", rdata_a[active], e[31:0]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int sel, input int n);
    en_a[sel] = 1'b0;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(mk(1, 1, 1, 0, 0, 32'd0));
      step();
    end
  endtask

  // One complete access: accept, wait states, DONE. Leaves the bench at the cycle after DONE.
  task automatic access(input int sel, input logic [31:0] a, input logic [3:0] w,
                        input logic [31:0] d, output logic [31:0] rd, output logic er,
                        output int sc);
    bit ok;
    int idx;
    bit chk;
    logic [31:0] exp_rd;
    model_eval(sel, a, w, ok, idx);
    chk    = !ok || known[sel][idx];
    exp_rd = ok ? mdl[sel][idx] : 32'd0;
    active = sel;
    en_a[sel] = 1'b1; addr_a[sel] = a; wen_a[sel] = w; wdata_a[sel] = d;
    sc = 0;
    for (int k = 0; k <= wait_of(sel); k++) begin
      exp_q.push_back(mk(1, 1, 1, 1, 0, 32'd0));
      #3;
      sc += int'(stall_a[sel]);
      step();
    end
    exp_q.push_back(mk(1, 1, chk, 0, !ok, exp_rd));
    #3;
    rd = rdata_a[sel];
    er = err_a[sel];
    if (ok) begin
      for (int b = 0; b < 4; b++)
        if (w[3-b]) mdl[sel][idx][31-8*b -: 8] = d[31-8*b -: 8];
      if (w == 4'b1111) known[sel][idx] = 1'b1;
    end
    step();
    en_a[sel] = 1'b0;
  endtask

  initial begin : drv_blk
    logic [31:0] rd;
    logic [31:0] a;
    logic [3:0]  w;
    logic [3:0]  oh;
    logic        er;
    int          sc;
    int          r;
    int          kind;

    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 1024; i++) begin
        mdl[s][i]   = 32'd0;
        known[s][i] = 1'b0;
      end
      en_a[s] = 1'b1; addr_a[s] = 32'h8; wen_a[s] = 4'b1111; wdata_a[s] = 32'hFFFF_FFFF;
    end
    rst = 1'b1;
    step();
    exp_q.push_back(mk(1, 1, 1, 0, 0, 32'd0));
    #2;
    check("rst_stall1", {31'b0, stall_a[1]}, 32'd0);
    check("rst_err1", {31'b0, err_a[1]}, 32'd0);
    check("rst_rdata1", rdata_a[1], 32'd0);
    step();
    rst = 1'b0;
    en_a[0] = 1'b0; en_a[1] = 1'b0;
    #2;
    check("rst_state0", {30'b0, dbg_a[0]}, 32'd0);
    check("rst_state1", {30'b0, dbg_a[1]}, 32'd0);
    idle(0, 1);

    // Directed: one wait state, base 0
    access(0, 32'h8, 4'b1111, 32'hDEAD_BEEF, rd, er, sc);
    check("store_stall_cycles", sc, 32'd2);
    access(0, 32'h8, 4'b0000, 32'h0, rd, er, sc);
    check("load_stall_cycles", sc, 32'd2);
    check("load_word", rd, 32'hDEAD_BEEF);
    access(0, 32'h9, 4'b0100, 32'h5555_5555, rd, er, sc);
    check("byte_store_old", rd, 32'hDEAD_BEEF);
    idle(0, 1);
    access(0, 32'h8, 4'b0000, 32'h0, rd, er, sc);
    check("after_byte", rd, 32'hDE55_BEEF);
    access(0, 32'hA, 4'b0011, 32'h1234_1234, rd, er, sc);
    access(0, 32'h8, 4'b0000, 32'h0, rd, er, sc);
    check("after_half", rd, 32'hDE55_1234);
    access(0, 32'h6, 4'b1111, 32'hAAAA_AAAA, rd, er, sc);
    check("misaligned_err", {31'b0, er}, 32'd1);
    check("misaligned_rdata", rd, 32'd0);
    access(0, 32'h9, 4'b1000, 32'hAAAA_AAAA, rd, er, sc);
    check("wrong_lane_err", {31'b0, er}, 32'd1);
    access(0, 32'h8, 4'b0000, 32'h0, rd, er, sc);
    check("unchanged_after_err", rd, 32'hDE55_1234);
    access(0, 32'h1000, 4'b0000, 32'h0, rd, er, sc);
    check("range_err", {31'b0, er}, 32'd1);
    check("range_stall_cycles", sc, 32'd2);
    access(0, 32'hFFC, 4'b1111, 32'hCAFE_F00D, rd, er, sc);
    check("last_word_err", {31'b0, er}, 32'd0);
    access(0, 32'hFFC, 4'b0000, 32'h0, rd, er, sc);
    check("last_word", rd, 32'hCAFE_F00D);

    // Reset while a store is waiting must drop the store.
    access(0, 32'h10, 4'b1111, 32'h1111_1111, rd, er, sc);
    en_a[0] = 1'b1; addr_a[0] = 32'h10; wen_a[0] = 4'b1111; wdata_a[0] = 32'h2222_2222;
    exp_q.push_back(mk(1, 1, 1, 1, 0, 32'd0));
    step();
    rst = 1'b1;
    exp_q.push_back(mk(0, 1, 1, 0, 0, 32'd0));
    step();
    rst = 1'b0;
    idle(0, 1);
    access(0, 32'h10, 4'b0000, 32'h0, rd, er, sc);
    check("rst_dropped_store", rd, 32'h1111_1111);

    // Directed: zero wait states, base 0x1000
    access(1, 32'h1008, 4'b1111, 32'hAABB_CCDD, rd, er, sc);
    check("w0_stall_cycles", sc, 32'd1);
    access(1, 32'h1008, 4'b0000, 32'h0, rd, er, sc);
    check("w0_load", rd, 32'hAABB_CCDD);
    access(1, 32'h0FFC, 4'b0000, 32'h0, rd, er, sc);
    check("below_base_err", {31'b0, er}, 32'd1);
    access(1, 32'h2000, 4'b0000, 32'h0, rd, er, sc);
    check("above_top_err", {31'b0, er}, 32'd1);

    // Random traffic on both instances
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 17; i++) begin
        r = (i < 16) ? i : 1023;
        access(s, base_of(s) + 32'(r) * 4, 4'b1111, $urandom, rd, er, sc);
      end
      for (int i = 0; i < 150; i++) begin
        r = $urandom_range(0, 19);
        if (r < 16)       a = base_of(s) + 32'(r) * 4;
        else if (r == 16) a = base_of(s) + 32'(1023) * 4;
        else if (r == 17) a = base_of(s) + 32'(1024) * 4;
        else if (r == 18) a = base_of(s) - 32'd4;
        else              a = 32'hFFFF_FFF0;
        a = a + 32'($urandom_range(0, 3));
        kind = $urandom_range(0, 4);
        oh = 4'b1000;
        case (kind)
          0:       w = 4'b0000;
          1:       w = 4'b1111;
          2:       w = a[1] ? 4'b0011 : 4'b1100;
          3:       w = oh >> a[1:0];
          default: w = 4'($urandom_range(0, 15));
        endcase
        access(s, a, w, $urandom, rd, er, sc);
        idle(s, $urandom_range(0, 2));
      end
    end

    idle(0, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
